// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun,
        StWaitDrop,
        StHalted
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect/halt controls and decoder handshake.
interface fetch_unit_if;

    logic                              imem_req;
    logic [31:0]                       imem_addr;
    logic                              imem_ack;
    logic [fetch_unit_pkg::INST_W-1:0] imem_rdata;
    logic                              redirect_valid;
    logic [31:0]                       redirect_pc;
    logic                              halt;
    logic                              inst_valid;
    logic                              inst_ready;
    logic [fetch_unit_pkg::INST_W-1:0] inst;
    logic [31:0]                       inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small shifting FIFO of fetched {inst, pc} entries; head is always entry 0.
module fetch_fifo import fetch_unit_pkg::*; #(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    fetch_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [CntW-1:0]          base;
    logic                     pop_ok, push_ok;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = entry_q[0];

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        pop_ok  = pop && !empty;
        // A pop frees a slot in the same cycle, so push is legal even when full.
        push_ok = push && (!full || pop_ok);
        base    = count_q - CntW'(pop_ok);
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    entry_d[i] = entry_q[i+1];
                end
            end
            if (push_ok) begin
                entry_d[base[IdxW-1:0]] = push_data;
            end
            count_d = base + CntW'(push_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a 2-entry buffer with redirect,
// halt, and drop of in-flight requests whose data is no longer wanted.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_addr_q, pend_addr_d;

    logic         req;
    logic [31:0]  addr;
    logic         pop, halt_fire, fire, stall;
    logic         push, flush;
    fetch_entry_t push_entry, fifo_head;
    logic         fifo_full, fifo_empty;

    assign pop       = !fifo_empty && bus.inst_ready;
    assign halt_fire = bus.halt && pop;
    assign fire      = req && bus.imem_ack;
    assign stall     = req && !bus.imem_ack;

    // An outstanding request keeps its original address even after pc is redirected.
    assign addr = pend_q ? pend_addr_q : pc_q;

    always_comb begin
        req = 1'b0;
        if (rst_n) begin
            req = pend_q || (state_q == StRun && (!fifo_full || pop) && !halt_fire);
        end
    end

    assign push       = (state_q == StRun) && fire && !bus.redirect_valid && !halt_fire;
    assign flush      = bus.redirect_valid || halt_fire;
    assign push_entry = '{inst: bus.imem_rdata, pc: pc_q};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = stall;
        pend_addr_d = stall ? addr : pend_addr_q;
        if (push) begin
            pc_d = pc_q + PC_STEP;
        end
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc & ~32'h3;
            state_d = stall ? StWaitDrop : StRun;
        end else begin
            unique case (state_q)
                StRun:      if (halt_fire) state_d = StHalted;
                StWaitDrop: if (fire) state_d = StRun;
                StHalted:   state_d = StHalted;
                default:    state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = addr;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = fifo_head.inst;
    assign bus.inst_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h0000_0204) ? 32'h0000_0073 : (a ^ 32'h5A5A_0000);
    endfunction

    assign bus.imem_rdata = word_at(bus.imem_addr);

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with ack/ready high so the request gating is exercised.
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.imem_ack       = 1'b1;
        bus.inst_ready     = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rst_inst", bus.inst, 32'd0);
        check_eq("rst_inst_pc", bus.inst_pc, 32'd0);

        // Streaming at one instruction per cycle.
        rst_n = 1'b1;
        #1;
        check_eq("first_req", 32'(bus.imem_req), 32'd1);
        check_eq("first_addr", bus.imem_addr, 32'd0);
        check_eq("first_valid", 32'(bus.inst_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("stream_addr", bus.imem_addr, 32'(4 * k));
            check_eq("stream_valid", 32'(bus.inst_valid), 32'd1);
            check_eq("stream_pc", bus.inst_pc, 32'(4 * (k - 1)));
            check_eq("stream_inst", bus.inst, word_at(32'(4 * (k - 1))));
        end

        // Decoder stall: buffer fills to two, requests stop, head holds.
        bus.inst_ready = 1'b0;
        #1;
        check_eq("stall_req0", 32'(bus.imem_req), 32'd1);
        check_eq("stall_addr0", bus.imem_addr, 32'h10);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("stall_req", 32'(bus.imem_req), 32'd0);
            check_eq("stall_pc", bus.inst_pc, 32'hC);
            check_eq("stall_inst", bus.inst, word_at(32'hC));
        end
        tick();
        bus.inst_ready = 1'b1;
        #1;
        check_eq("drain_pc0", bus.inst_pc, 32'hC);
        check_eq("drain_req", 32'(bus.imem_req), 32'd1);
        check_eq("drain_addr", bus.imem_addr, 32'h14);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("drain_pc", bus.inst_pc, 32'(12 + 4 * k));
        end

        // Redirect while a request is stalled: it completes unchanged and is dropped.
        do_reset();
        bus.inst_ready = 1'b1;
        #1;
        check_eq("wd_addr0", bus.imem_addr, 32'h0);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        check_eq("wd_addr1", bus.imem_addr, 32'h0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("wd_req2", 32'(bus.imem_req), 32'd1);
        check_eq("wd_addr2", bus.imem_addr, 32'h0);
        tick();
        bus.imem_ack = 1'b1;
        #1;
        check_eq("wd_addr3", bus.imem_addr, 32'h0);
        tick();
        check_eq("wd_dropped", 32'(bus.inst_valid), 32'd0);
        check_eq("wd_new_addr", bus.imem_addr, 32'h40);
        tick();
        check_eq("wd_new_pc", bus.inst_pc, 32'h40);
        check_eq("wd_new_inst", bus.inst, word_at(32'h40));

        // Redirect coinciding with an ack discards the returned word.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("rda_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rda_addr", bus.imem_addr, 32'h200);
        tick();
        check_eq("rda_pc", bus.inst_pc, 32'h200);

        // Halt on the presented instruction, then resume via redirect.
        tick();
        check_eq("halt_inst", bus.inst, 32'h0000_0073);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("halted_req", 32'(bus.imem_req), 32'd0);
            check_eq("halted_valid", 32'(bus.inst_valid), 32'd0);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("resume_req", 32'(bus.imem_req), 32'd1);
        check_eq("resume_addr", bus.imem_addr, 32'h100);
        tick();
        check_eq("resume_pc", bus.inst_pc, 32'h100);

        // Unaligned redirect near the top of memory, then wrap to zero.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
        check_eq("wrap_addr0", bus.imem_addr, 32'h0);
        tick();
        check_eq("wrap_pc0", bus.inst_pc, 32'h0);

        // Reset mid-request with two entries buffered.
        bus.inst_ready = 1'b0;
        tick();
        check_eq("full_req", 32'(bus.imem_req), 32'd0);
        check_eq("full_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        bus.imem_ack   = 1'b0;
        #1;
        check_eq("mid_req", 32'(bus.imem_req), 32'd1);
        check_eq("mid_addr", bus.imem_addr, 32'h8);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(bus.imem_req), 32'd0);
        check_eq("arst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("arst_pc", bus.inst_pc, 32'h0);
        tick();
        tick();
        rst_n        = 1'b1;
        bus.imem_ack = 1'b1;
        #1;
        check_eq("restart_addr", bus.imem_addr, 32'h0);
        check_eq("restart_req", 32'(bus.imem_req), 32'd1);
        tick();
        check_eq("restart_pc", bus.inst_pc, 32'h0);
        check_eq("restart_valid", 32'(bus.inst_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 Parameter FIFO_DEPTH, default 2, meaning the number of fetched-instruction buffer entries (fixed at 2 in this revision).
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 Port imem_req, output, 1, instruction memory read request.
REQ-006 Port imem_addr, output, 32, word-aligned fetch address.
REQ-007 Port imem_ack, input, 1, memory accepts the request and returns data in the same cycle.
REQ-008 Port imem_rdata, input, 32, instruction word, valid when imem_req && imem_ack.
REQ-009 Port redirect_valid, input, 1, branch/JAL taken, restart fetch.
REQ-010 Port redirect_pc, input, 32, redirect target.
REQ-011 Port halt, input, 1, decoder stop indication for the instruction currently presented.
REQ-012 Port inst_valid, output, 1, inst/inst_pc hold a valid instruction for the decoder.
REQ-013 Port inst_ready, input, 1, decoder accepts inst this cycle.
REQ-014 Port inst, output, 32, instruction word to the decoder.
REQ-015 Port inst_pc, output, 32, address of inst.

Function
REQ-016 State machine SHALL have states RUN, WAIT_DROP, HALTED.
REQ-017 imem_req SHALL assert in RUN when FIFO occupancy after this cycle's pop is below FIFO_DEPTH; once high it SHALL stay high with imem_addr stable until imem_ack.
REQ-018 On imem_req && imem_ack in RUN, {imem_rdata, pc} SHALL be pushed to the FIFO and pc SHALL become pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 inst_valid SHALL be high exactly when the FIFO is non-empty; inst/inst_pc SHALL be the FIFO head and SHALL remain stable while inst_valid && !inst_ready.
REQ-020 Latency: data acked at edge N SHALL appear on inst_valid in cycle N+1; with imem_ack and inst_ready tied high, throughput SHALL be one instruction per cycle.
REQ-021 Push and pop in the same cycle SHALL be allowed at any occupancy, including full.
REQ-022 On redirect_valid, the FIFO SHALL be flushed and pc SHALL load {redirect_pc[31:2], 2'b00} on that edge.
REQ-023 If redirect_valid occurs while imem_req is high without imem_ack, the state SHALL go to WAIT_DROP; the pending request SHALL complete unchanged, its data SHALL be discarded on ack, then the state SHALL return to RUN and fetch from the redirect pc.
REQ-024 If redirect_valid coincides with imem_ack, the returned data SHALL be discarded and the state SHALL remain RUN.
REQ-025 halt && inst_valid && inst_ready SHALL move the state to HALTED, flush the FIFO, and block new requests; an unacked request in flight SHALL complete with its data discarded.
REQ-026 HALTED SHALL be left only by redirect_valid (to RUN or WAIT_DROP per REQ-023) or reset.
REQ-027 When redirect_valid and the halt handshake occur in the same cycle, redirect SHALL take priority.
REQ-028 halt without inst_valid && inst_ready SHALL be ignored.

Reset
REQ-029 While rst_n is low: pc = RESET_PC, state = RUN, FIFO empty, imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-030 The first imem_req SHALL assert in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-request SHALL abandon the request without waiting for imem_ack.

Structure
REQ-032 A shared package SHALL hold the fetch state enum, the INST_W=32 and PC_STEP=4 constants, and the default RESET_PC.
REQ-033 The 2-entry FIFO SHALL be a sub-module fetch_fifo (push/pop/flush, full/empty, 64-bit entries).

Verification
REQ-034 Reset release, imem_ack=1, inst_ready=1 -> addresses 0,4,8,... on consecutive cycles; inst_pc=0 in the first cycle after the first ack.
REQ-035 inst_ready=0 for 5 cycles -> exactly 2 instructions buffered, imem_req low, inst stable; inst_ready=1 -> in-order delivery, no loss or duplication.
REQ-036 imem_ack held low 3 cycles with redirect_pc=32'h40 in cycle 1 -> imem_addr stable; the acked word is dropped; the next request uses addr 32'h40; the next inst_pc is 32'h40.
REQ-037 Present inst 32'h0000_0073 with halt=1, inst_ready=1 -> HALTED, no imem_req for 10 cycles; redirect_pc=32'h100 -> fetch resumes at 32'h100.
REQ-038 redirect_pc=32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then wrap to 32'h0000_0000.
REQ-039 rst_n low mid-request with 2 entries buffered -> inst_valid and imem_req low immediately; restart at RESET_PC.
